console_text_pipeline: RTL and testbench
========================================

# console_text_pipeline

Pixel-rate text-mode renderer for the console overlay. Takes raster coordinates from the video timing generator, sequences reads from the character/attribute RAM and the font ROM, and applies the 16-entry VGA palette, blink and a hardware cursor. Emits one 24-bit RGB pixel per clock, with fixed latency, towards the HDMI encoder.

## Interface
- COLS, 80, text columns
- ROWS, 25, text rows
- CHAR_H, 16, font rows per cell; power of two. Cell width is fixed at 8 pixels.
- ADDR_W, $clog2(COLS*ROWS), text RAM address width
- clk  in  1  pixel clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- x  in  11  raster column, from the timing generator
- y  in  11  raster row
- de  in  1  active video for this x/y
- frame_start  in  1  one-cycle pulse, once per frame during vertical blanking
- blink_en  in  1  1: attr[7] means blink; 0: attr[7] means bright background (bg index = attr[7:4])
- cursor_en  in  1  cursor enable
- cursor_col  in  7  cursor cell column
- cursor_row  in  5  cursor cell row
- text_addr  out  ADDR_W  character/attribute RAM address
- text_data  in  16  {attr[7:0], char[7:0]}; 1-cycle synchronous read
- font_addr  out  8+$clog2(CHAR_H)  {char, font row}
- font_data  in  8  font row, MSB is leftmost pixel; 1-cycle synchronous read
- rgb  out  24  pixel colour
- rgb_de  out  1  de delayed to align with rgb

## Operation
- Cell coordinates: col = x>>3, crow = y / CHAR_H, fine_y = y % CHAR_H, fine_x = x[2:0].
- Text address: text_addr = crow*COLS + col.
- Font address: font_addr = {char, fine_y}.
- Pixel selection: pix = font_data[7 - fine_x].
- Foreground index: fg_idx = attr[3:0].
- Background index:
  - bg_idx = {1'b0, attr[6:4]} when blink_en = 1.
  - bg_idx = attr[7:4] when blink_en = 0.
- Palette, index 0..F:
  - 000000, 0000AA, 00AA00, 00AAAA, AA0000, AA00AA, AA5500, AAAAAA
  - 555555, 5555FF, 55FF55, 55FFFF, FF5555, FF55FF, FFFF55, FFFFFF
- Frame counter: 5-bit frame_cnt increments on every frame_start and wraps 31 -> 0.
  - text_hide = blink_en & attr[7] & frame_cnt[4]. When set, pix is treated as 0.
  - cursor_on = cursor_en & (col == cursor_col) & (crow == cursor_row) & (fine_y >= CHAR_H-2) & ~frame_cnt[3]. When set, pix is forced to 1, overriding text_hide.
- Output: rgb = pix ? palette[fg_idx] : palette[bg_idx].
- Pixels outside the text area: when col >= COLS or crow >= ROWS, the pixel is treated as 0 with attr = 00, giving black.
  - text_addr is still driven in this case; its value is don't-care.
- Blanking: rgb = 0 whenever the aligned de is 0.

## Timing
- Pipeline stages, for inputs sampled at edge N:
  - Edge N: text_addr registered.
  - Edge N+1: text_data valid at the RAM output.
  - Edge N+2: font_addr registered, and attr captured.
  - Edge N+3: font_data valid.
  - Edge N+4: rgb and rgb_de registered.
- Latency is exactly 5 clocks from x/y/de to rgb/rgb_de; throughput is 1 pixel per clock with no stalls.
- Delay registers carry de, fine_x, the out-of-range flag and the cursor hit alongside the RAM/ROM reads.
- frame_cnt is read at the final stage. A frame_start pulse during active video changes the phase for every pixel whose final stage is at or after that edge; there is no error.
- Reset, asynchronous on rst_n low, clears:
  - rgb = 0, rgb_de = 0, text_addr = 0, font_addr = 0
  - frame_cnt = 0
  - all delayed de bits = 0
- Release from reset is followed by 5 clocks of rgb_de = 0 before valid pixels appear.
- Reset mid-line drops the in-flight pixels.
- blink_en and the cursor inputs are quasi-static. They are sampled at stage 0 and travel with the pixel.

## Structure
- Package console_pkg holds:
  - the palette function vga_rgb(logic [3:0]) -> logic [23:0]
  - typedef attr_t (packed: blink/bright, bg[2:0], fg[3:0])
  - constant CHAR_W = 8
  - the frame-counter bit positions BLINK_BIT = 4 and CURSOR_BIT = 3
- One sub-module, console_blink_timer, contains frame_cnt and outputs text_phase and cursor_phase.
- The pipeline stays in console_text_pipeline.

## Test plan
- Cell decode: x=17, y=35, CHAR_H=16 -> text_addr = 2*80+2 = 162.
  - Then text_data = 1F41 -> font_addr = {41, 3}.
  - Then font_data = 40 with fine_x = 1 -> rgb = FFFFFF and rgb_de = 1, exactly 5 clocks after input.
- Background and blanking: same cell with font_data = 00 -> rgb = 0000AA.
  - de = 0 at the input -> rgb = 0 and rgb_de = 0.
- Blink: attr = 8E with blink_en = 1.
  - After 16 frame_start pulses, lit pixels -> 000000 (bg 0).
  - After 16 more pulses -> FFFF55.
  - With blink_en = 0, the same attr gives bg index 8 -> 555555 on unlit pixels.
- Cursor: cursor at (5,3), cursor_en = 1, y = 3*16+15, x = 40..47.
  - Before any frame_start pulse (frame_cnt = 0) -> fg colour on all 8 pixels, even with font_data = 00.
  - After 8 frame_start pulses -> normal text.
- Out of area: x = 640, y = 0 with de = 1 -> rgb = 000000 regardless of text_data.
- Reset: assert rst_n = 0 mid-line -> rgb and rgb_de are 0 immediately.
  - After release, the first valid rgb_de is 5 clocks after the first de.
  - frame_cnt restarts at 0.

Source files
------------

// File: rtl/console_pkg.sv
// Shared types and constants for the console text renderer: VGA palette, attribute layout,
// and the frame-counter bit positions used for blink and cursor timing.
package console_pkg;
  localparam int CHAR_W     = 8;
  localparam int BLINK_BIT  = 4;
  localparam int CURSOR_BIT = 3;

  typedef struct packed {
    logic       blink;  // blink or bright-background, depending on blink_en
    logic [2:0] bg;
    logic [3:0] fg;
  } attr_t;

  function automatic logic [23:0] vga_rgb(input logic [3:0] idx);
    logic [23:0] c;
    case (idx)
      4'h0: c = 24'h000000;
      4'h1: c = 24'h0000AA;
      4'h2: c = 24'h00AA00;
      4'h3: c = 24'h00AAAA;
      4'h4: c = 24'hAA0000;
      4'h5: c = 24'hAA00AA;
      4'h6: c = 24'hAA5500;
      4'h7: c = 24'hAAAAAA;
      4'h8: c = 24'h555555;
      4'h9: c = 24'h5555FF;
      4'hA: c = 24'h55FF55;
      4'hB: c = 24'h55FFFF;
      4'hC: c = 24'hFF5555;
      4'hD: c = 24'hFF55FF;
      4'hE: c = 24'hFFFF55;
      default: c = 24'hFFFFFF;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/console_text_pipeline_if.sv
// Character/attribute RAM and font ROM read bus between the renderer and its memories.
interface console_text_pipeline_if #(
  parameter int ADDR_W  = 11,
  parameter int FONT_AW = 12
);
  logic [ADDR_W-1:0]  text_addr;
  logic [15:0]        text_data;
  logic [FONT_AW-1:0] font_addr;
  logic [7:0]         font_data;

  modport master (output text_addr, output font_addr, input text_data, input font_data);
  modport slave  (input text_addr, input font_addr, output text_data, output font_data);
endinterface

// File: rtl/console_blink_timer.sv
// Per-frame counter that provides the text-blink and cursor-blink phases.
module console_blink_timer
  import console_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  output logic text_phase,
  output logic cursor_phase
);
  logic [4:0] frame_cnt_d, frame_cnt_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start) frame_cnt_d = frame_cnt_q + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  // text_phase=1 hides blinking text; cursor_phase=1 shows the cursor
  assign text_phase   = frame_cnt_q[BLINK_BIT];
  assign cursor_phase = ~frame_cnt_q[CURSOR_BIT];
endmodule

// File: rtl/console_text_pipeline.sv
// Five-stage text-mode renderer: cell decode -> text RAM -> font ROM -> palette/blink/cursor -> RGB.
module console_text_pipeline
  import console_pkg::*;
#(
  parameter int COLS    = 80,
  parameter int ROWS    = 25,
  parameter int CHAR_H  = 16,
  parameter int ADDR_W  = $clog2(COLS*ROWS),
  parameter int FONT_AW = 8 + $clog2(CHAR_H)
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        de,
  input  logic        frame_start,
  input  logic        blink_en,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  console_text_pipeline_if.master mem,
  output logic [23:0] rgb,
  output logic        rgb_de
);
  localparam int FY_W   = $clog2(CHAR_H);
  localparam int STAGES = 4;

  typedef struct packed {
    logic [2:0]      fine_x;
    logic [FY_W-1:0] fine_y;
    logic            oor;
    logic            cur;
    logic            blink_en;
  } side_t;

  logic [7:0]  col;
  logic [10:0] crow;
  side_t       side0;
  side_t       side_q [1:STAGES];
  logic [STAGES:0] vld_pipe;

  logic [ADDR_W-1:0]  text_addr_d, text_addr_q;
  logic [FONT_AW-1:0] font_addr_d, font_addr_q;
  attr_t attr_d, attr_q, attr2_q;
  logic [23:0] rgb_d, rgb_q;
  logic        rgb_de_d, rgb_de_q;
  logic        text_phase, cursor_phase;
  attr_t       attr_f;
  logic        pix;
  logic [3:0]  bg_idx;

  console_blink_timer u_blink (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .text_phase   (text_phase),
    .cursor_phase (cursor_phase)
  );

  // Stage 0: cell decode from raster position
  always_comb begin
    col             = x[10:3];
    crow            = y >> FY_W;
    side0.fine_x    = x[2:0];
    side0.fine_y    = y[FY_W-1:0];
    side0.oor       = (32'(col) >= COLS) || (32'(crow) >= ROWS);
    side0.cur       = cursor_en && (col == {1'b0, cursor_col}) && (crow == {6'd0, cursor_row}) &&
                      (32'(side0.fine_y) >= CHAR_H - 2);
    side0.blink_en  = blink_en;
    text_addr_d     = ADDR_W'(32'(crow) * COLS + 32'(col));
    vld_pipe[0]     = de;
  end

  // Stage 2: RAM word is valid; form the font address and grab the attribute
  always_comb begin
    font_addr_d = {mem.text_data[7:0], side_q[2].fine_y};
    attr_d      = attr_t'(mem.text_data[15:8]);
  end

  // Final stage: font row valid; resolve pixel, blink, cursor and palette
  always_comb begin
    attr_f = side_q[STAGES].oor ? attr_t'(8'h00) : attr2_q;
    pix    = side_q[STAGES].oor ? 1'b0 : mem.font_data[3'd7 - side_q[STAGES].fine_x];
    if (side_q[STAGES].blink_en && attr_f.blink && text_phase) pix = 1'b0;
    if (side_q[STAGES].cur && cursor_phase) pix = 1'b1;
    bg_idx   = side_q[STAGES].blink_en ? {1'b0, attr_f.bg} : {attr_f.blink, attr_f.bg};
    rgb_de_d = vld_pipe[STAGES];
    rgb_d    = '0;
    if (vld_pipe[STAGES]) rgb_d = pix ? vga_rgb(attr_f.fg) : vga_rgb(bg_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      for (int i = 1; i <= STAGES; i++) side_q[i] <= '0;
      text_addr_q <= '0;
      font_addr_q <= '0;
      attr_q      <= '0;
      attr2_q     <= '0;
      rgb_q       <= '0;
      rgb_de_q    <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      side_q[1] <= side0;
      for (int i = 2; i <= STAGES; i++) side_q[i] <= side_q[i-1];
      text_addr_q <= text_addr_d;
      font_addr_q <= font_addr_d;
      attr_q      <= attr_d;
      attr2_q     <= attr_q;
      rgb_q       <= rgb_d;
      rgb_de_q    <= rgb_de_d;
    end
  end

  assign mem.text_addr = text_addr_q;
  assign mem.font_addr = font_addr_q;
  assign rgb           = rgb_q;
  assign rgb_de        = rgb_de_q;
endmodule

// File: tb/tb_console_text_pipeline.sv
// Directed bench for console_text_pipeline with behavioural text RAM and font ROM.
module tb_console_text_pipeline;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x, y;
  logic        de, frame_start, blink_en, cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [23:0] rgb;
  logic        rgb_de;
  int checks = 0;
  int errors = 0;

  logic [15:0] text_mem [0:2047];
  logic [7:0]  font_mem [0:4095];

  console_text_pipeline_if #(.ADDR_W(11), .FONT_AW(12)) mem ();

  console_text_pipeline dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .de(de), .frame_start(frame_start),
    .blink_en(blink_en), .cursor_en(cursor_en), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .mem(mem), .rgb(rgb), .rgb_de(rgb_de)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem.text_data <= text_mem[mem.text_addr];
    mem.font_data <= font_mem[mem.font_addr];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1; tick(1);
      frame_start = 1'b0; tick(1);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; x = '0; y = '0; de = 1'b0; frame_start = 1'b0;
    blink_en = 1'b1; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    for (int i = 0; i < 2048; i++) text_mem[i] = '0;
    for (int i = 0; i < 4096; i++) font_mem[i] = '0;
    text_mem[162] = 16'h1F41;
    font_mem[12'h413] = 8'h40;

    tick(3);
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_de", 32'(rgb_de), 32'h0);
    chk("rst_taddr", 32'(mem.text_addr), 32'h0);
    chk("rst_faddr", 32'(mem.font_addr), 32'h0);
    rst_n = 1'b1; tick(2);

    // cell decode with a single-cycle de pulse to pin latency
    x = 11'd17; y = 11'd35; de = 1'b1; tick(1);
    chk("text_addr", 32'(mem.text_addr), 32'd162);
    de = 1'b0; tick(2);
    chk("font_addr", 32'(mem.font_addr), 32'h413);
    tick(1);
    chk("de_early", 32'(rgb_de), 32'h0);
    tick(1);
    chk("fg_rgb", 32'(rgb), 32'hFFFFFF);
    chk("fg_de", 32'(rgb_de), 32'h1);
    tick(1);
    chk("de_after", 32'(rgb_de), 32'h0);
    chk("rgb_after", 32'(rgb), 32'h0);

    font_mem[12'h413] = 8'h00; de = 1'b1; tick(5);
    chk("bg_rgb", 32'(rgb), 32'h0000AA);
    chk("bg_de", 32'(rgb_de), 32'h1);
    de = 1'b0; tick(5);
    chk("blank_rgb", 32'(rgb), 32'h0);
    chk("blank_de", 32'(rgb_de), 32'h0);

    // blink
    text_mem[162] = 16'h8E41; font_mem[12'h413] = 8'h40; de = 1'b1; tick(5);
    chk("blink_vis0", 32'(rgb), 32'hFFFF55);
    pulses(16); tick(5);
    chk("blink_hid", 32'(rgb), 32'h000000);
    pulses(16); tick(5);
    chk("blink_vis1", 32'(rgb), 32'hFFFF55);
    blink_en = 1'b0; x = 11'd16; tick(5);
    chk("bright_bg", 32'(rgb), 32'h555555);
    x = 11'd17; tick(5);
    chk("bright_fg", 32'(rgb), 32'hFFFF55);

    // cursor
    blink_en = 1'b1; cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd3;
    text_mem[245] = 16'h0A20; font_mem[12'h20F] = 8'hF0; font_mem[12'h20D] = 8'h00;
    y = 11'd63;
    for (int xi = 40; xi < 48; xi++) begin
      x = 11'(xi); tick(5);
      chk("cursor_on", 32'(rgb), 32'h55FF55);
    end
    y = 11'd61; x = 11'd44; tick(5);
    chk("cursor_row13", 32'(rgb), 32'h000000);
    pulses(8); y = 11'd63;
    for (int xi = 40; xi < 48; xi++) begin
      x = 11'(xi); tick(5);
      chk("cursor_off", 32'(rgb), (xi < 44) ? 32'h55FF55 : 32'h000000);
    end

    // out of area, and the last in-range cell
    cursor_en = 1'b0;
    text_mem[80] = 16'h1F41; font_mem[12'h410] = 8'hFF;
    x = 11'd640; y = 11'd0; tick(5);
    chk("oor_col", 32'(rgb), 32'h000000);
    chk("oor_de", 32'(rgb_de), 32'h1);
    text_mem[2000] = 16'h1F41;
    x = 11'd0; y = 11'd400; tick(5);
    chk("oor_row", 32'(rgb), 32'h000000);
    text_mem[1999] = 16'h1F41; font_mem[12'h41F] = 8'h01;
    x = 11'd639; y = 11'd399; tick(5);
    chk("last_cell", 32'(rgb), 32'hFFFFFF);

    // reset mid-line with frame_cnt = 16
    x = 11'd16; y = 11'd35; pulses(8); blink_en = 1'b0; tick(5);
    chk("pre_rst_rgb", 32'(rgb), 32'h555555);
    #2 rst_n = 1'b0; #1;
    chk("rst_mid_rgb", 32'(rgb), 32'h0);
    chk("rst_mid_de", 32'(rgb_de), 32'h0);
    tick(3);
    blink_en = 1'b1; x = 11'd17; de = 1'b1; rst_n = 1'b1;
    tick(4);
    chk("rel_de4", 32'(rgb_de), 32'h0);
    tick(1);
    chk("rel_de5", 32'(rgb_de), 32'h1);
    chk("rel_cnt0", 32'(rgb), 32'hFFFF55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
